// File: rtl/uart_fifo_sending_pkg.sv
// Shared types and constant helpers for the FIFO-fed UART transmitter.
// UART_FIFO_SENDING_PARITY_EN adds the PARITY state to the enum.
package uart_fifo_sending_pkg;

`ifdef UART_FIFO_SENDING_PARITY_EN
  typedef enum logic [2:0] {
    ST_GAP    = 3'd0,
    ST_IDLE   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_GAP   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd5
  } state_e;
`endif

  function automatic int unsigned bit_period(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // One counter serves both bit periods and the inter-frame gap.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with occupancy counter; pushes while full are ignored,
// pops while empty are ignored. DEPTH must be a power of two, >= 2.
module uart_byte_fifo #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_en, rd_en;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign wr_en   = push && !full;
  assign rd_en   = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en && !rd_en)      count_d = count_q + (AW+1)'(1);
    else if (!wr_en && rd_en) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_fifo_sending.sv
// FIFO-fed 8N1 UART transmitter with an idle gap after every frame and after reset.
// Define UART_FIFO_SENDING_PARITY_EN to insert an even-parity bit before the stop bit.
//
// state  | meaning
// GAP    | line idle, counting wait_time cycles
// IDLE   | waiting for a byte; pops head when FIFO non-empty
// START  | start bit (0) for one bit period
// DATA   | 8 data bits LSB first, one bit period each
// PARITY | even parity bit (only with parity enabled)
// STOP   | stop bit (1), then back to GAP
module uart_fifo_sending #(
  parameter int unsigned clk_freq   = 1000000,
  parameter int unsigned baud_rate  = 9600,
  parameter int unsigned wait_time  = 1000,
  parameter int unsigned fifo_depth = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       push,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       busy,
  output logic       tx
);
  import uart_fifo_sending_pkg::*;

  localparam int unsigned BIT_CYC = bit_period(clk_freq, baud_rate);
  localparam int unsigned CW      = cnt_width(BIT_CYC, wait_time);
  localparam int unsigned AW      = $clog2(fifo_depth);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(wait_time - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    byte_q, byte_d;
  logic          tx_q, tx_d;
  logic          overflow_q, overflow_d;
  logic          pop;
  logic [7:0]    head;
  logic [AW:0]   fifo_count;

  uart_byte_fifo #(.DEPTH(fifo_depth)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (data_in),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    pop     = 1'b0;
    case (state_q)
      ST_GAP: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else cnt_d = cnt_q + CW'(1);
      end
      ST_IDLE: begin
        if (fifo_count != '0) begin
          pop     = 1'b1;
          byte_d  = head;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end else cnt_d = cnt_q + CW'(1);
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
`ifdef UART_FIFO_SENDING_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else idx_d = idx_q + 3'd1;
        end else cnt_d = cnt_q + CW'(1);
      end
`ifdef UART_FIFO_SENDING_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_STOP;
        end else cnt_d = cnt_q + CW'(1);
      end
`endif
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else cnt_d = cnt_q + CW'(1);
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_GAP;
      end
    endcase
  end

  // tx follows the registered state, so it lags the FSM by one cycle.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = byte_q[idx_q];
`ifdef UART_FIFO_SENDING_PARITY_EN
      ST_PARITY: tx_d = ^byte_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  assign overflow_d = overflow_q | (push & full);
  assign busy       = (state_q != ST_IDLE);
  assign tx         = tx_q;
  assign overflow   = overflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_GAP;
      cnt_q      <= '0;
      idx_q      <= '0;
      byte_q     <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_uart_fifo_sending.sv
// Scoreboard bench: pushes queue expected bytes, a line monitor decodes tx frames.
module tb_uart_fifo_sending;
  localparam int BP   = 208;
  localparam int WAIT = 100;
`ifdef UART_FIFO_SENDING_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int LIMIT = 25000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       full, empty, overflow, busy, tx;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  logic [7:0] exp_q[$];
  int         exp_t[$];

  uart_fifo_sending #(
    .clk_freq(2_000_000), .baud_rate(9600), .wait_time(WAIT), .fifo_depth(8)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .push(push),
    .full(full), .empty(empty), .overflow(overflow), .busy(busy), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_push(input logic [7:0] b, input bit expect_sent);
    push = 1'b1;
    data_in = b;
    @(posedge clk); #1;
    push = 1'b0;
    if (expect_sent) begin
      exp_q.push_back(b);
      exp_t.push_back(cyc);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < LIMIT) begin tick(1); n++; end
    check(name, (n < LIMIT) ? 1 : 0, 1);
  endtask

  // Line monitor: samples tx every cycle, checks each bit is flat for BP cycles.
  initial begin : monitor
    logic [NB-1:0] bits;
    logic [7:0]    eb;
    int            et, t0, last_end;
    bit            unstable, aborted, have_prev;
    have_prev = 0;
    last_end  = 0;
    forever begin
      @(posedge clk); #1;
      if (reset) have_prev = 0;
      else if (tx === 1'b0) begin
        t0 = cyc; unstable = 0; aborted = 0; bits = '0;
        for (int k = 0; k < NB*BP; k++) begin
          if (k > 0) begin @(posedge clk); #1; end
          if (reset) begin aborted = 1; break; end
          if (k % BP == 0) bits[k/BP] = tx;
          else if (tx !== bits[k/BP]) unstable = 1;
        end
        if (aborted) have_prev = 0;
        else begin
          n_chk++;
          if (exp_q.size() == 0)
            $display("FAIL frame_expected: unexpected frame 0x%02h with empty scoreboard", bits[8:1]);
          else begin
            n_pass++;
            eb = exp_q.pop_front();
            et = exp_t.pop_front();
            check("frame_data", int'(bits[8:1]), int'(eb));
            check("bit_period_stable", int'(unstable), 0);
`ifdef UART_FIFO_SENDING_PARITY_EN
            check("parity_bit", int'(bits[9]), int'(^eb));
            check("stop_bit", int'(bits[10]), 1);
`else
            check("stop_bit", int'(bits[9]), 1);
`endif
            if (have_prev && et <= last_end)
              check("stop_to_start_gap", t0 - last_end - 1, WAIT + 1);
          end
          have_prev = 1;
          last_end  = cyc;
        end
      end
    end
  end

  initial begin : main
    int n, lows;
    reset = 1'b1;
    tick(3);
    check("rst_tx", tx, 1);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 1);
    reset = 1'b0;

    // 9 pushes during the post-reset gap: the 9th is dropped.
    for (int i = 0; i < 9; i++) begin
      do_push(8'(i), i < 8);
      if (i == 0) check("empty_after_push", empty, 0);
      if (i == 6) check("full_at_7", full, 0);
      if (i == 7) begin
        check("full_at_8", full, 1);
        check("ovf_before_drop", overflow, 0);
      end
      if (i == 8) begin
        check("ovf_after_drop", overflow, 1);
        check("full_after_drop", full, 1);
      end
    end
    tick(90);
    check("gap_busy_cycle99", busy, 1);
    tick(1);
    check("gap_done_cycle100", busy, 0);
    check("full_before_pop", full, 1);
    // Push lands on the same edge as the first pop: dropped, count 8 -> 7.
    do_push(8'hEE, 1'b0);
    check("full_after_push_pop", full, 0);
    check("ovf_after_push_pop", overflow, 1);
    check("busy_in_start", busy, 1);
    wait_drain("drain_burst");

    // Push into empty FIFO while idle: tx low two edges later.
    do_push(8'h61, 1'b1);
    tick(1);
    check("latency_edge1_tx", tx, 1);
    tick(1);
    check("latency_edge2_tx", tx, 0);
    wait_drain("drain_0x61");

    do_push(8'h41, 1'b1);
    do_push(8'h42, 1'b1);
    do_push(8'h07, 1'b1);
    wait_drain("drain_b2b");

    // Reset in the middle of data bit 4 of 0xA5.
    do_push(8'hA5, 1'b1);
    n = 0;
    while (tx !== 1'b0 && n < 1000) begin tick(1); n++; end
    check("a5_start_seen", (n < 1000) ? 1 : 0, 1);
    tick(5*BP + 100);
    check("pre_reset_bit4", tx, 0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_empty", empty, 1);
    check("async_rst_busy", busy, 1);
    check("async_rst_overflow", overflow, 0);
    exp_q.delete();
    exp_t.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (tx !== 1'b1) lows++;
    end
    check("no_frame_after_reset", lows, 0);
    check("idle_after_reset_gap", busy, 0);
    do_push(8'h33, 1'b1);
    wait_drain("drain_0x33");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
